apb_rr_arbiter: RTL

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_rr_grant.sv | 29 ++
 rtl/apb_rr_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the two-requester APB round-robin arbiter:
//   - ADDR_W / DATA_W : APB address and data widths (8 bits each)
//   - apb_state_e     : bus FSM encoding (IDLE=00, SETUP=01, ACCESS=10)
//   - apb_req_t       : request latched at accept time and replayed on the bus
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;   // already zero for reads
        logic              id;      // requester that owns the transfer
    } apb_req_t;

endpackage

// File: rtl/apb_rr_grant.sv
// -----------------------------------------------------------------------------
// apb_rr_grant
// Purely combinational round-robin pick between two requesters.
// Ports:
//   req0_valid, req1_valid : in  pending requests
//   last_grant             : in  id of the requester granted most recently
//   grant_id               : out winning requester (meaningful when grant_valid)
//   grant_valid            : out at least one requester is pending
// -----------------------------------------------------------------------------
module apb_rr_grant (
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic last_grant,
    output logic grant_id,
    output logic grant_valid
);

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            // Tie: the requester that was not served last goes next.
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
// Two-requester round-robin front end driving a single APB completer.
// Ports:
//   pclk, prst                 : clock, synchronous active-low reset
//   reqN_valid/write/addr/wdata: requester N transfer request (N=0,1)
//   reqN_ready                 : combinational accept strobe (IDLE only)
//   rspN_valid/rdata/err       : one-cycle completion pulse to requester N
//   psel, penable, pwrite,
//   paddr, pwdata              : APB requester-side outputs
//   pready, prdata             : APB completer response
// Parameter MAX_WAIT (1..255): ACCESS cycles with pready low before abort.
// -----------------------------------------------------------------------------
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              pclk,
    input  logic              prst,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    // Count value seen on the last permitted wait cycle; one more miss aborts.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    apb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [7:0]        wait_q, wait_d;
    apb_req_t          req_q, req_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic grant_id;
    logic grant_valid;
    logic accept;

    apb_rr_grant u_grant (
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .last_grant  (last_grant_q),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Gated by prst so no accept strobe is seen while reset is asserted.
    assign accept     = grant_valid & prst & (state_q == IDLE);
    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept &  grant_id;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_d       = wait_q;
        req_d        = req_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.id     = grant_id;
                    req_d.write  = grant_id ? req1_write : req0_write;
                    req_d.addr   = grant_id ? req1_addr  : req0_addr;
                    if (grant_id ? req1_write : req0_write) begin
                        req_d.wdata = grant_id ? req1_wdata : req0_wdata;
                    end else begin
                        req_d.wdata = '0;
                    end
                    last_grant_d = grant_id;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = req_q.id;
                    rsp_rdata_d = req_q.write ? '0 : prdata;
                end else if (wait_q == WAIT_LAST) begin
                    // This miss brings the count to MAX_WAIT: abort.
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = req_q.id;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!prst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wait_q       <= '0;
            req_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_q       <= wait_d;
            req_q        <= req_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable = (state_q == ACCESS);
    assign pwrite  = req_q.write;
    assign paddr   = req_q.addr;
    assign pwdata  = req_q.wdata;

    assign rsp0_valid = rsp_valid_q & ~rsp_id_q;
    assign rsp1_valid = rsp_valid_q &  rsp_id_q;
    assign rsp0_rdata = rsp0_valid ? rsp_rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rsp_rdata_q : '0;
    assign rsp0_err   = rsp0_valid & rsp_err_q;
    assign rsp1_err   = rsp1_valid & rsp_err_q;

endmodule
